dcache_port_arbiter: RTL and testbench
======================================

# dcache_port_arbiter

Arbitrates the three data-cache request ports (PTW, load unit, store unit) onto the single request path of the direct-mapped dcache controller. Sits between the CPU-side ports and the cache FSM. Latches the winning request's payload and holds the cache request until it is accepted. Steers completion back to the owning port, then releases the cache for the next arbitration.

## Interface
Parameters:
- NumPorts, 3: number of requesters; index equals `request_port_select_t` (0 = PTW, 1 = LOAD, 2 = STORE).
- MaxWait, 8: starvation threshold in cycles. Used only with the starvation guard.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NumPorts  per-port request valid.
- req_data_i  in  NumPorts x dcache_port_req_t  per-port payload: addr (PLEN), wdata (XLEN), be (XLEN/8), size (2), we (1).
- gnt_o  out  NumPorts  one-hot grant; payload is captured in the same cycle.
- rvalid_o  out  NumPorts  one-hot load-data valid.
- rdata_o  out  XLEN  read data, broadcast to all ports.
- cache_req_o  out  1  request to the cache FSM.
- cache_req_data_o  out  dcache_port_req_t  latched payload.
- cache_port_o  out  request_port_select_t  owner of the current transaction.
- cache_gnt_i  in  1  cache accepted `cache_req_o`.
- cache_done_i  in  1  transaction complete (load data or store written).
- cache_rdata_i  in  XLEN  load data, valid with `cache_done_i`.
- busy_o  out  1  high whenever the state is not ARB_IDLE.

## Operation
- FSM states (`dcache_arb_state_t`):
  - ARB_IDLE: if any bit of `req_i` is set, pick a winner and assert `gnt_o[winner]`. Latch `req_data_i[winner]` into payload_q and the winner into sel_q. Go to ARB_REQ.
  - ARB_REQ: `cache_req_o`=1 driving payload_q.
    - `cache_gnt_i` alone: go to ARB_WAIT_DONE.
    - `cache_gnt_i` and `cache_done_i` in the same cycle: complete immediately and go to ARB_IDLE.
    - `cache_done_i` without `cache_gnt_i`: ignored.
  - ARB_WAIT_DONE: on `cache_done_i`, complete and go to ARB_IDLE.
- Complete: `rvalid_o[sel_q]` = `cache_done_i & ~payload_q.we` (combinational pass-through). `rdata_o` = `cache_rdata_i`. Stores receive no rvalid.
- Winner selection: fixed priority PTW > LOAD > STORE, unless overridden by the starvation guard.
- Requests arriving while not in ARB_IDLE get no grant and must be held by the port.
- A port may drop `req_i` after its grant; the transaction still completes.
- `gnt_o` is asserted only in ARB_IDLE, at most one bit per cycle.

## Timing
- Reset values:
  - state = ARB_IDLE; sel_q = PTW_PORT; payload_q = '0; wait counters = 0.
  - All outputs 0, except `cache_port_o` = PTW_PORT.
- A request at cycle N in ARB_IDLE gets `gnt_o` at cycle N and `cache_req_o` at cycle N+1.
- With cache_gnt and done in the same cycle, the minimum period from grant to the next grant is 2 cycles. Otherwise it is 3 cycles plus cache latency.
- `rvalid_o` asserts in the same cycle as `cache_done_i`; it is never registered.
- An asynchronous reset mid-transaction aborts it: no rvalid is produced, and the cache must be reset by the same `rst_ni`.
- `cache_req_data_o` is stable from ARB_REQ entry until the state leaves ARB_REQ.

## Configuration
- `DCACHE_ARB_STARVATION_GUARD_EN` defined:
  - Each port has a saturating counter of width $clog2(MaxWait+1).
  - The counter increments every cycle its `req_i` is high and it is not granted, and clears on grant or when `req_i` is low.
  - Any port whose counter equals MaxWait wins over fixed priority; ties go to the lowest index.
- Not defined: counters are absent and arbitration is strict fixed priority. The STORE port can starve under continuous PTW/LOAD traffic.

## Structure
- Add to dcache_pkg: `dcache_arb_state_t` {ARB_IDLE, ARB_REQ, ARB_WAIT_DONE}, the `dcache_port_req_t` struct, and the constant DCACHE_ARB_MAX_WAIT = 8.
- One combinational sub-module, `dcache_arb_priority_pick`:
  - Inputs: `req`, the starved mask.
  - Output: one-hot winner plus index.
  - Reusable by any future extra port.

## Test plan
- Reset, then idle → all outputs 0 and `busy_o`=0. Assert `rst_ni` low mid-ARB_WAIT_DONE → next cycle ARB_IDLE with no `rvalid_o`.
- `req_i`=3'b111 in ARB_IDLE → `gnt_o`=3'b001 the same cycle; `cache_req_o`=1 next cycle with the PTW payload; `cache_port_o`=PTW_PORT.
- LOAD request at 0x8000_0010, `cache_gnt_i` at +2, `cache_done_i` at +5 with rdata 0xDEADBEEF → `rvalid_o`=3'b010 and `rdata_o`=0xDEADBEEF at +5; next arbitration at +6.
- STORE request, `cache_gnt_i` and `cache_done_i` together → no `rvalid_o`; ARB_IDLE next cycle.
- With the guard and MaxWait=8: LOAD held high continuously, STORE held high → STORE granted on its first ARB_IDLE after its counter reaches 8. Without the guard, STORE is never granted.
- Port drops `req_i` the cycle after its grant → payload unchanged on `cache_req_data_o` until `cache_gnt_i`.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the data-cache port arbiter.
// Optional starvation guard: DCACHE_ARB_STARVATION_GUARD_EN.
package dcache_pkg;

    localparam int XLEN = 32;
    localparam int PLEN = 32;

    localparam int DCACHE_ARB_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        PTW_PORT   = 2'd0,
        LOAD_PORT  = 2'd1,
        STORE_PORT = 2'd2
    } request_port_select_t;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_REQ       = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } dcache_arb_state_t;

    typedef struct packed {
        logic [PLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
        logic [XLEN/8-1:0]   be;
        logic [1:0]          size;
        logic                we;
    } dcache_port_req_t;

endpackage

// File: rtl/dcache_arb_priority_pick.sv
// Lowest-index-wins picker; starved requesters take precedence.
// Used by dcache_port_arbiter (DCACHE_ARB_STARVATION_GUARD_EN feeds starved_i).
module dcache_arb_priority_pick #(
    parameter int N    = 3,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    starved_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [N-1:0] hot;
    logic [N-1:0] cand;

    assign hot     = req_i & starved_i;
    assign cand    = (|hot) ? hot : req_i;
    assign valid_o = |req_i;

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates PTW/LOAD/STORE ports onto the single dcache request path.
// Define DCACHE_ARB_STARVATION_GUARD_EN to enable per-port wait counters.
module dcache_port_arbiter
    import dcache_pkg::*;
#(
    parameter int NumPorts = 3,
    parameter int MaxWait  = DCACHE_ARB_MAX_WAIT
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  dcache_port_req_t [NumPorts-1:0]     req_data_i,
    output logic [NumPorts-1:0]                 gnt_o,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [XLEN-1:0]                     rdata_o,
    output logic                                cache_req_o,
    output dcache_port_req_t                    cache_req_data_o,
    output request_port_select_t                cache_port_o,
    input  logic                                cache_gnt_i,
    input  logic                                cache_done_i,
    input  logic [XLEN-1:0]                     cache_rdata_i,
    output logic                                busy_o
);

    localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    dcache_arb_state_t    state_q, state_d;
    request_port_select_t sel_q, sel_d;
    dcache_port_req_t     payload_q, payload_d;

    logic [NumPorts-1:0] starved;
    logic [NumPorts-1:0] pick_gnt;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_valid;

    dcache_arb_priority_pick #(
        .N    (NumPorts),
        .IdxW (IdxW)
    ) u_pick (
        .req_i     (req_i),
        .starved_i (starved),
        .gnt_o     (pick_gnt),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

`ifdef DCACHE_ARB_STARVATION_GUARD_EN
    localparam int              CntW   = $clog2(MaxWait + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

    logic [NumPorts-1:0][CntW-1:0] wait_q, wait_d;

    always_comb begin
        starved = '0;
        for (int i = 0; i < NumPorts; i++) begin
            starved[i] = req_i[i] && (wait_q[i] == CntMax);
        end
    end

    // Counts cycles spent requesting without a grant, saturating at MaxWait.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < NumPorts; i++) begin
            if (!req_i[i] || gnt_o[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != CntMax) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign starved = '0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        payload_d   = payload_q;
        gnt_o       = '0;
        rvalid_o    = '0;
        cache_req_o = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_o     = pick_gnt;
                    sel_d     = request_port_select_t'(pick_idx);
                    payload_d = req_data_i[pick_idx];
                    state_d   = ARB_REQ;
                end
            end
            ARB_REQ: begin
                cache_req_o = 1'b1;
                // A done without acceptance does not belong to us.
                if (cache_gnt_i) begin
                    if (cache_done_i) begin
                        rvalid_o[sel_q] = ~payload_q.we;
                        state_d         = ARB_IDLE;
                    end else begin
                        state_d = ARB_WAIT_DONE;
                    end
                end
            end
            ARB_WAIT_DONE: begin
                if (cache_done_i) begin
                    rvalid_o[sel_q] = ~payload_q.we;
                    state_d         = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            sel_q     <= PTW_PORT;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            payload_q <= payload_d;
        end
    end

    assign rdata_o          = cache_rdata_i;
    assign cache_req_data_o = payload_q;
    assign cache_port_o     = sel_q;
    assign busy_o           = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized + directed bench for dcache_port_arbiter.
// Reference model tracks one outstanding transaction record.
module tb_dcache_port_arbiter;
    import dcache_pkg::*;

    localparam int NP = 3;
    localparam int MW = DCACHE_ARB_MAX_WAIT;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NP-1:0]                 req;
    dcache_port_req_t [NP-1:0]     rdat;
    logic [NP-1:0]                 gnt, rvalid;
    logic [XLEN-1:0]               rdata, c_rdata;
    logic                          c_req, c_gnt, c_done, busy;
    dcache_port_req_t              c_data;
    request_port_select_t          c_port;

    int n_chk  = 0;
    int n_pass = 0;
    int store_gnts = 0;

    // Model: an outstanding transaction (owner, payload, accepted flag).
    bit               m_busy;
    bit               m_acc;
    int               m_own;
    dcache_port_req_t m_pl;
    int               m_wait [NP];

    always #5 clk = ~clk;

    dcache_port_arbiter #(.NumPorts(NP), .MaxWait(MW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_i            (req),
        .req_data_i       (rdat),
        .gnt_o            (gnt),
        .rvalid_o         (rvalid),
        .rdata_o          (rdata),
        .cache_req_o      (c_req),
        .cache_req_data_o (c_data),
        .cache_port_o     (c_port),
        .cache_gnt_i      (c_gnt),
        .cache_done_i     (c_done),
        .cache_rdata_i    (c_rdata),
        .busy_o           (busy)
    );

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_acc  = 0;
        m_own  = 0;
        m_pl   = '0;
        for (int i = 0; i < NP; i++) m_wait[i] = 0;
    endtask

    function automatic int pick(logic [NP-1:0] r);
        int w;
        w = -1;
`ifdef DCACHE_ARB_STARVATION_GUARD_EN
        for (int i = 0; i < NP; i++)
            if (w < 0 && r[i] && m_wait[i] == MW) w = i;
`endif
        for (int i = 0; i < NP; i++)
            if (w < 0 && r[i]) w = i;
        return w;
    endfunction

    task automatic rand_port(int i);
        logic [31:0] a, d, m;
        a = $urandom;
        d = $urandom;
        m = $urandom;
        rdat[i].addr  = a;
        rdat[i].wdata = d;
        rdat[i].be    = m[3:0];
        rdat[i].size  = m[5:4];
        rdat[i].we    = m[6];
    endtask

    // Called at a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        logic [NP-1:0] eg, ev;
        int  w;
        bit  done_now;
        #1;
        eg = '0;
        ev = '0;
        w  = -1;
        if (!m_busy && |req) begin
            w = pick(req);
            eg[w] = 1'b1;
        end
        done_now = m_busy && c_done && (m_acc || c_gnt);
        if (done_now && !m_pl.we) ev[m_own] = 1'b1;
        chk("gnt", gnt, eg);
        chk("rvalid", rvalid, ev);
        chk("rdata", rdata, c_rdata);
        chk("cache_req", c_req, m_busy && !m_acc);
        chk("payload", c_data, m_pl);
        chk("port", c_port, m_own);
        chk("busy", busy, m_busy);
        if (eg[2]) store_gnts++;
        @(posedge clk);
        for (int i = 0; i < NP; i++) begin
            if (req[i] && !eg[i]) m_wait[i] = (m_wait[i] < MW) ? m_wait[i] + 1 : MW;
            else m_wait[i] = 0;
        end
        if (w >= 0) begin
            m_busy = 1;
            m_acc  = 0;
            m_own  = w;
            m_pl   = rdat[w];
        end else if (m_busy) begin
            if (c_gnt) m_acc = 1;
            if (done_now) m_busy = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        req = '0;
        c_gnt = 1'b1;
        c_done = 1'b1;
        for (int k = 0; k < 4 && m_busy; k++) step();
        c_gnt = 1'b0;
        c_done = 1'b0;
    endtask

    dcache_port_req_t saved;

    initial begin
        req = '0;
        rdat = '0;
        c_gnt = 1'b0;
        c_done = 1'b0;
        c_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_creq", c_req, 0);
        chk("rst_payload", c_data, 0);
        chk("rst_port", c_port, PTW_PORT);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // All three request: PTW wins.
        for (int i = 0; i < NP; i++) rand_port(i);
        saved = rdat[0];
        req = 3'b111;
        #1 chk("all_gnt", gnt, 3'b001);
        step();
        #1;
        chk("all_creq", c_req, 1'b1);
        chk("all_payload", c_data, saved);
        chk("all_port", c_port, PTW_PORT);
        drain();

        // LOAD with cache latency: gnt at +2, done at +5.
        rand_port(1);
        rdat[1].addr = 32'h8000_0010;
        rdat[1].we   = 1'b0;
        req = 3'b010;
        step();
        req = '0;
        step();
        c_gnt = 1'b1;
        step();
        c_gnt = 1'b0;
        step();
        step();
        c_done = 1'b1;
        c_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_rvalid", rvalid, 3'b010);
        chk("ld_rdata", rdata, 32'hDEAD_BEEF);
        step();
        c_done = 1'b0;
        req = 3'b001;
        #1 chk("ld_next_gnt", gnt, 3'b001);
        step();
        drain();

        // STORE with gnt and done together.
        rand_port(2);
        rdat[2].we = 1'b1;
        req = 3'b100;
        step();
        req = '0;
        c_gnt = 1'b1;
        c_done = 1'b1;
        #1 chk("st_rvalid", rvalid, 3'b000);
        step();
        c_gnt = 1'b0;
        c_done = 1'b0;
        #1 chk("st_idle", busy, 1'b0);
        step();

        // Port drops req after grant; payload must hold.
        rand_port(1);
        saved = rdat[1];
        req = 3'b010;
        step();
        req = '0;
        for (int k = 0; k < 3; k++) begin
            rand_port(1);
            #1 chk("drop_payload", c_data, saved);
            step();
        end
        c_gnt = 1'b1;
        step();
        c_gnt = 1'b0;
        c_done = 1'b1;
        step();
        c_done = 1'b0;

        // LOAD and STORE held high against a fast cache.
        store_gnts = 0;
        req = 3'b110;
        c_gnt = 1'b1;
        c_done = 1'b1;
        repeat (30) step();
`ifdef DCACHE_ARB_STARVATION_GUARD_EN
        chk("starve_store", store_gnts > 0, 1'b1);
`else
        chk("starve_store", store_gnts, 0);
`endif
        drain();

        // Reset in the middle of ARB_WAIT_DONE.
        req = 3'b001;
        step();
        req = '0;
        c_gnt = 1'b1;
        step();
        c_gnt = 1'b0;
        step();
        c_done = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 3'b000);
        chk("mid_rst_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        c_done = 1'b0;
        rst_n = 1'b1;
        step();

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            req = NP'($urandom);
            for (int i = 0; i < NP; i++) rand_port(i);
            c_gnt = ($urandom_range(0, 2) == 0);
            c_done = ($urandom_range(0, 2) == 0);
            c_rdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
